booth4_sel_gen: RTL and testbench
=================================

Name: booth4_sel_gen

Overview:
- Radix-4 Booth recoder/sequencer that sits directly upstream of the 4:1 partial-product select mux (mux4_1) in the radix-4 multiplier.
- Loads a signed multiplier and emits one Booth digit per handshake, least-significant digit first.
- Each digit is a 2-bit mux select plus a negate flag, consumed by the partial-product/accumulate stage.

Parameters:
- WIDTH, 8, multiplier width in bits; must be even and >= 4; digit count = WIDTH/2.
- IDX_W, $clog2(WIDTH/2), width of the digit index output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  load request; sampled only in IDLE
- mult  input  WIDTH  two's-complement multiplier; captured on an accepted start
- busy  output  1  high from the cycle after start is accepted until done
- sel_valid  output  1  digit outputs are valid
- sel_ready  input  1  downstream accepts the digit
- sel  output  2  mux select: 00 = zero, 01 = 1xM, 10 = 2xM, 11 never driven
- neg  output  1  digit is negative; downstream complements the selected product and adds 1
- digit_idx  output  IDX_W  digit position i; weight is 4^i
- last  output  1  current digit is the final digit
- done  output  1  one-cycle pulse after the final digit handshake

Behaviour:
- Reset (synchronous, active-high) dominates everything, including mid-operation. After reset: state = IDLE, busy = 0, sel_valid = 0, sel = 00, neg = 0, digit_idx = 0, last = 0, done = 0. Any in-flight digits are discarded.
- States: IDLE, EMIT, DONE.
- IDLE:
  - On start = 1, load shift register sr[WIDTH:0] <= {mult, 1'b0} and clear digit_idx to 0.
  - Go to EMIT; busy = 1 from the next cycle.
- EMIT:
  - sel_valid = 1. The digit is decoded combinationally from triplet sr[2:0] = (b2i+1, b2i, b2i-1).
  - Decode table: 000 -> 0; 001 and 010 -> +1; 011 -> +2; 100 -> -2; 101 and 110 -> -1; 111 -> 0.
  - Sign: neg = 1 only for -1 and -2. Zero digits always have neg = 0.
  - last = 1 when digit_idx == WIDTH/2 - 1.
  - On handshake (sel_valid and sel_ready): sr shifts right by 2 with sign extension and digit_idx increments.
  - If last, go to DONE.
  - While sel_ready = 0, sel, neg, digit_idx and last hold stable. Latency is 1 cycle per digit when sel_ready is held high.
- DONE: done = 1 and busy = 1 for one cycle, sel_valid = 0, then return to IDLE.
- start while busy is ignored; mult is sampled only on an accepted start. start in the DONE cycle is ignored.
- Throughput: WIDTH/2 + 2 cycles per operand minimum (load + WIDTH/2 digits + DONE).
- The sum of digit_i x 4^i equals the signed value of mult for every input, including the most negative value.

Optional Feature:
- Macro: BOOTH4_SKIP_ZERO_EN.
- Defined:
  - In EMIT, a non-final digit that decodes to 0 is skipped: sel_valid stays 0 for that cycle, sr shifts, digit_idx increments, and no handshake is required.
  - The final digit is always emitted, even when zero, so that last and done sequencing is unchanged.
  - Adds output nz_count [IDX_W:0], holding the number of non-zero digits emitted; cleared on start and on reset.
- Undefined: every digit is emitted, including zeros, and the nz_count port is absent.

Decomposition:
- Shared package booth4_pkg holds:
  - the select encodings SEL_ZERO = 2'b00, SEL_1M = 2'b01, SEL_2M = 2'b10;
  - the state enum (IDLE, EMIT, DONE);
  - the digit struct {sel, neg}.
- One natural sub-module: booth4_digit_dec, a purely combinational triplet -> {sel, neg} decoder, reused by the later parallel variant.

Test Plan (WIDTH = 8):
- mult = 8'h07, sel_ready = 1 -> digits (sel, neg) = (01,1), (10,0), (00,0), (00,0); last on idx 3; done pulses the next cycle; -1 + 2x4 = 7.
- mult = 8'h80 -> (00,0), (00,0), (00,0), (10,1), i.e. -2 x 64 = -128. With BOOTH4_SKIP_ZERO_EN: only idx 3 is emitted and nz_count = 1.
- mult = 8'hFF -> (01,1) at idx 0, then three (00,0) digits; reconstructed value = -1.
- mult = 8'h5A, sel_ready toggled 0/1 every cycle -> outputs stay stable while sel_ready is low; exactly 4 handshakes; digits -2, -1, +2, +1 (value 90).
- Reset asserted in EMIT at idx 2 -> next cycle all outputs are at reset values and state is IDLE; a following start with mult = 8'h07 runs the full sequence correctly.
- start held high throughout an operation with a different mult -> ignored until IDLE; done pulses exactly once per accepted start.

Source files
------------

// File: rtl/booth4_pkg.sv
// Shared definitions for the radix-4 Booth recoder family.
// Holds the partial-product select encodings, the sequencer state type and
// the decoded digit record used by booth4_digit_dec and booth4_sel_gen.
package booth4_pkg;

  // Partial-product mux select encodings (2'b11 is never driven)
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_1M   = 2'b01;
  localparam logic [1:0] SEL_2M   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] sel;
    logic       neg;
  } digit_t;

  function automatic logic digit_is_zero(input digit_t d);
    return (d.sel == SEL_ZERO);
  endfunction

endpackage

// File: rtl/booth4_digit_dec.sv
// Combinational radix-4 Booth triplet decoder.
// Maps (b2i+1, b2i, b2i-1) to a mux select and negate flag. Zero digits
// always carry neg = 0 so the downstream adder never injects a stray +1.
module booth4_digit_dec
  import booth4_pkg::*;
(
  input  logic [2:0] i_trip,
  output digit_t     o_digit
);

  // Triplet to {sel, neg} lookup
  always_comb begin
    o_digit.sel = SEL_ZERO;
    o_digit.neg = 1'b0;
    case (i_trip)
      3'b001, 3'b010: begin o_digit.sel = SEL_1M; o_digit.neg = 1'b0; end
      3'b011:         begin o_digit.sel = SEL_2M; o_digit.neg = 1'b0; end
      3'b100:         begin o_digit.sel = SEL_2M; o_digit.neg = 1'b1; end
      3'b101, 3'b110: begin o_digit.sel = SEL_1M; o_digit.neg = 1'b1; end
      default:        begin o_digit.sel = SEL_ZERO; o_digit.neg = 1'b0; end
    endcase
  end

endmodule

// File: rtl/booth4_sel_gen.sv
// Radix-4 Booth recoder/sequencer feeding the partial-product select mux.
// Loads a signed multiplier and hands out one digit per valid/ready
// handshake, least-significant digit first.
// Optional build macro BOOTH4_SKIP_ZERO_EN: non-final zero digits are
// skipped without a handshake and an nz_count output is added.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; mult captured into the shift register
// EMIT  | presenting digit sr[2:0]; advances on handshake (or skip)
// DONE  | one-cycle done pulse, busy still high, then back to IDLE
module booth4_sel_gen
  import booth4_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH/2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mult,
  output logic             busy,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [1:0]       sel,
  output logic             neg,
  output logic [IDX_W-1:0] digit_idx,
  output logic             last,
  output logic             done
`ifdef BOOTH4_SKIP_ZERO_EN
  ,
  output logic [IDX_W:0]   nz_count
`endif
);

  localparam int               NDIG     = WIDTH / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  state_t           r_state;
  logic [WIDTH:0]   r_sr;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic             r_done;

  digit_t w_digit;
  logic   w_emit;
  logic   w_last;
  logic   w_skip;
  logic   w_valid;
  logic   w_hs;
  logic   w_adv;

  booth4_digit_dec u_dec (
    .i_trip  (r_sr[2:0]),
    .o_digit (w_digit)
  );

  // Digit presentation and handshake qualification
  always_comb begin
    w_emit = (r_state == EMIT);
    w_last = w_emit && (r_idx == LAST_IDX);
`ifdef BOOTH4_SKIP_ZERO_EN
    w_skip = w_emit && !w_last && digit_is_zero(w_digit);
`else
    w_skip = 1'b0;
`endif
    w_valid = w_emit && !w_skip;
    w_hs    = w_valid && sel_ready;
    w_adv   = w_hs || w_skip;
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sel_valid = w_valid;
  assign sel       = w_emit ? w_digit.sel : SEL_ZERO;
  assign neg       = w_emit ? w_digit.neg : 1'b0;
  assign digit_idx = r_idx;
  assign last      = w_last;

  // Sequencer: load, shift per digit with sign extension, done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sr    <= {mult, 1'b0};
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (w_adv) begin
            r_sr <= {r_sr[WIDTH], r_sr[WIDTH], r_sr[WIDTH:2]};
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef BOOTH4_SKIP_ZERO_EN
  logic [IDX_W:0] r_nz_count;

  // Count non-zero digits actually handed downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nz_count <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_nz_count <= '0;
    end else if (w_hs && !digit_is_zero(w_digit)) begin
      r_nz_count <= r_nz_count + 1'b1;
    end
  end

  assign nz_count = r_nz_count;
`endif

endmodule

// File: tb/tb_booth4_sel_gen.sv
// Self-checking bench for booth4_sel_gen (WIDTH = 8).
// A reference Booth model pushes expected digits into a queue when an
// operand is launched; a negedge monitor pops and compares on handshakes.
module tb_booth4_sel_gen;

  localparam int WIDTH = 8;
  localparam int IDX_W = 2;
  localparam int NDIG  = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] mult;
  logic             busy;
  logic             sel_valid;
  logic             sel_ready;
  logic [1:0]       sel;
  logic             neg;
  logic [IDX_W-1:0] digit_idx;
  logic             last;
  logic             done;
`ifdef BOOTH4_SKIP_ZERO_EN
  logic [IDX_W:0]   nz_count;
`endif

  booth4_sel_gen #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mult      (mult),
    .busy      (busy),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .sel       (sel),
    .neg       (neg),
    .digit_idx (digit_idx),
    .last      (last),
    .done      (done)
`ifdef BOOTH4_SKIP_ZERO_EN
    ,
    .nz_count  (nz_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       neg;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;
  int recon    = 0;
  int exp_n    = 0;
  int exp_nz   = 0;
  logic mon_en = 1'b0;

  logic       p_stall = 1'b0;
  logic [1:0] p_sel;
  logic       p_neg;
  logic [1:0] p_idx;
  logic       p_last;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference Booth recoding straight from the digit definition
  task automatic push_model(input logic [7:0] m);
    int   d;
    logic bm1;
    exp_t e;
    exp_n  = 0;
    exp_nz = 0;
    for (int i = 0; i < NDIG; i++) begin
      bm1 = (i == 0) ? 1'b0 : m[2*i-1];
      d = -2 * int'(m[2*i+1]) + int'(m[2*i]) + int'(bm1);
`ifdef BOOTH4_SKIP_ZERO_EN
      if (d == 0 && i != NDIG-1) continue;
`endif
      e.sel  = 2'((d < 0) ? -d : d);
      e.neg  = (d < 0);
      e.idx  = 2'(i);
      e.last = (i == NDIG-1);
      q.push_back(e);
      exp_n++;
      if (d != 0) exp_nz++;
    end
  endtask

  // Monitor: compare digits on handshake, check stall stability, count done
  always @(negedge clk) begin
    if (!mon_en) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("stall_valid", 32'(sel_valid), 1);
        chk("stall_sel",   32'(sel),       32'(p_sel));
        chk("stall_neg",   32'(neg),       32'(p_neg));
        chk("stall_idx",   32'(digit_idx), 32'(p_idx));
        chk("stall_last",  32'(last),      32'(p_last));
      end
      if (sel_valid && sel_ready) begin
        if (q.size() == 0) begin
          chk("extra_digit", 1, 0);
        end else begin
          mon_e = q.pop_front();
          chk("dig_sel",  32'(sel),       32'(mon_e.sel));
          chk("dig_neg",  32'(neg),       32'(mon_e.neg));
          chk("dig_idx",  32'(digit_idx), 32'(mon_e.idx));
          chk("dig_last", 32'(last),      32'(mon_e.last));
        end
        hs_cnt++;
        recon += (neg ? -int'(sel) : int'(sel)) * (1 << (2 * int'(digit_idx)));
      end
      p_stall = sel_valid && !sel_ready;
      p_sel   = sel;
      p_neg   = neg;
      p_idx   = digit_idx;
      p_last  = last;
      if (done) done_cnt++;
    end
  end

  // One operand: launch, wait for done (bounded), then check totals
  task automatic run_op(input logic [7:0] m, input bit toggle,
                        input bit hold_start, input logic [7:0] m_alt);
    int  b_hs, b_done, b_recon, cycles;
    bit  seen;
    push_model(m);
    b_hs    = hs_cnt;
    b_done  = done_cnt;
    b_recon = recon;
    @(posedge clk); #1;
    start     = 1'b1;
    mult      = m;
    sel_ready = toggle ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    mult   = m_alt;
    cycles = 1;
    seen   = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    while (!seen && cycles < 200) begin
      if (toggle) sel_ready = ~sel_ready;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk("done_busy",  32'(busy),      1);
        chk("done_valid", 32'(sel_valid), 0);
      end else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    if (!toggle) chk("latency", cycles, NDIG + 1);
    @(posedge clk); #1;
    start     = 1'b0;
    sel_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy",   32'(busy), 0);
    chk("done_once",   done_cnt - b_done, 1);
    chk("handshakes",  hs_cnt - b_hs, exp_n);
    chk("queue_empty", q.size(), 0);
    chk("recon_value", recon - b_recon, $signed(m));
`ifdef BOOTH4_SKIP_ZERO_EN
    chk("nz_count", 32'(nz_count), exp_nz);
`endif
  endtask

  initial begin
    int lim;
    rst       = 1'b1;
    start     = 1'b0;
    mult      = '0;
    sel_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy),      0);
    chk("rst_valid", 32'(sel_valid), 0);
    chk("rst_sel",   32'(sel),       0);
    chk("rst_neg",   32'(neg),       0);
    chk("rst_idx",   32'(digit_idx), 0);
    chk("rst_last",  32'(last),      0);
    chk("rst_done",  32'(done),      0);
    rst    = 1'b0;
    mon_en = 1'b1;

    run_op(8'h07, 1'b0, 1'b0, 8'h00);
    run_op(8'h80, 1'b0, 1'b0, 8'h00);
    run_op(8'hFF, 1'b0, 1'b0, 8'h00);
    run_op(8'h5A, 1'b1, 1'b0, 8'h00);

    // Reset in the middle of EMIT at digit index 2
    push_model(8'h07);
    @(posedge clk); #1;
    start = 1'b1;
    mult  = 8'h07;
    @(posedge clk); #1;
    start = 1'b0;
    lim   = 0;
    while (!(busy && !done && digit_idx == 2'd2) && lim < 20) begin
      @(posedge clk); #1;
      lim++;
    end
    chk("reach_idx2", 32'(lim < 20), 1);
    mon_en    = 1'b0;
    sel_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy",  32'(busy),      0);
    chk("mid_rst_valid", 32'(sel_valid), 0);
    chk("mid_rst_sel",   32'(sel),       0);
    chk("mid_rst_neg",   32'(neg),       0);
    chk("mid_rst_idx",   32'(digit_idx), 0);
    chk("mid_rst_last",  32'(last),      0);
    chk("mid_rst_done",  32'(done),      0);
    rst = 1'b0;
    q.delete();
    sel_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy), 0);
    mon_en = 1'b1;
    run_op(8'h07, 1'b0, 1'b0, 8'h00);

    // start held high with mult changing mid-operation
    run_op(8'h33, 1'b0, 1'b1, 8'hC5);

    run_op(8'h7F, 1'b0, 1'b0, 8'h00);
    run_op(8'h01, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 6; k++) begin
      run_op(8'($urandom_range(255)), 1'(k & 1), 1'b0, 8'($urandom_range(255)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
